// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding, default width and the two's-complement
// magnitude helper for the sequential signed multiplier (mult_seq_ctrl).
// The optional build macro MULT_EARLY_TERM_EN is consumed in mult_seq_ctrl.
package mult_pkg;

   // Default operand width; the product is twice as wide.
   localparam int DEFAULT_N = 5;

   // Widest operand the magnitude helper handles. Callers sign-extend their
   // operand to this width, so operands must be narrower than MAX_N.
   localparam int MAX_N = 32;

   // Controller states: accept operands, iterate partial products,
   // apply the sign, present the product.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } stateT;

   // Magnitude of a sign-extended two's-complement value. Because the input
   // is sign-extended from a narrower operand, the most negative operand
   // value maps to its positive magnitude without wrapping.
   function automatic logic [MAX_N-1:0] twosMag(input logic [MAX_N-1:0] value);
      return value[MAX_N-1] ? (~value + MAX_N'(1)) : value;
   endfunction

endpackage

// File: rtl/mult_accum_adder.sv
// mult_accum_adder: plain W-bit adder with carry-in and carry-out. It is the
// only adder in the multiplier; keeping it in its own module lets the adder
// architecture change without touching the controller.
module mult_accum_adder #(
   parameter int W = 10
) (
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         ci,
   output logic [W-1:0] sum,
   output logic         co
);

   // Widen every term by one bit so the carry-out is captured exactly.
   assign {co, sum} = (W+1)'(A) + (W+1)'(B) + (W+1)'(ci);

endmodule

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequential signed N x N -> 2N multiplier controller.
// Operands arrive over in_valid/in_ready, magnitudes are multiplied by
// shift-and-add (one multiplier bit per cycle through mult_accum_adder),
// the sign is applied in a single FIX cycle through the same adder, and the
// product leaves over p_valid/p_ready.
// Build option: define MULT_EARLY_TERM_EN to leave RUN as soon as the
// remaining multiplier bits are all zero; product values do not change.
module mult_seq_ctrl
   import mult_pkg::*;
#(
   parameter int N = DEFAULT_N   // operand width, 2 <= N < MAX_N
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           p_valid,
   input  logic           p_ready,
   output logic [2*N-1:0] p,
   output logic           busy
);

   localparam int PW = 2 * N;
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

   stateT         state;
   stateT         nextState;

   logic [N-1:0]  magA;        // |a|, held for the whole transaction
   logic [N-1:0]  magB;        // |b|, shifted right one bit per RUN cycle
   logic          sign;        // product sign
   logic [PW-1:0] acc;         // running magnitude of the product
   logic [CW-1:0] cnt;         // RUN iteration index = current shift amount
   logic [PW-1:0] pReg;        // signed product presented in DONE

   logic [MAX_N-1:0] aWide;
   logic [MAX_N-1:0] bWide;

   logic [PW-1:0] addA;
   logic [PW-1:0] addB;
   logic          addCi;
   logic [PW-1:0] addSum;
   logic          unusedCarry; // acc cannot overflow, so the carry is never needed

   logic          accept;
   logic          runDone;
   logic          prodTaken;

   // Sign-extend operands so the magnitude helper sees a true negative value.
   assign aWide = {{(MAX_N - N){a[N-1]}}, a};
   assign bWide = {{(MAX_N - N){b[N-1]}}, b};

   assign accept    = in_valid && (state == IDLE);
   assign prodTaken = p_ready && (state == DONE);

`ifdef MULT_EARLY_TERM_EN
   // Finish RUN when this edge consumes the last set multiplier bit, or after N bits.
   assign runDone = (cnt == LAST_CNT) || ((magB >> 1) == '0);
`else
   // Always iterate over all N multiplier bits so latency is data-independent.
   assign runDone = (cnt == LAST_CNT);
`endif

   // Route the shared adder: accumulate in RUN, two's-complement negate in FIX.
   always_comb begin
      addA  = acc;
      addB  = ({{N{1'b0}}, magA}) << cnt;
      addCi = 1'b0;
      if (state == FIX) begin
         // ~acc + 1 for negative products; acc + 0 otherwise. ~0 + 1 wraps to 0,
         // so a zero product stays zero.
         addA  = sign ? ~acc : acc;
         addB  = '0;
         addCi = sign;
      end
   end

   mult_accum_adder #(
      .W (PW)
   ) u_adder (
      .A   (addA),
      .B   (addB),
      .ci  (addCi),
      .sum (addSum),
      .co  (unusedCarry)
   );

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential logic uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic.
   always_comb begin
      // NOTE: default assignment first so every path drives nextState and no
      // latch is inferred.
      nextState = state;
      unique case (state)
         IDLE: if (accept)    nextState = RUN;
         RUN:  if (runDone)   nextState = FIX;
         FIX:                 nextState = DONE;
         DONE: if (prodTaken) nextState = IDLE;
         default:             nextState = IDLE;
      endcase
   end

   // Handshake and status outputs decoded from the current state.
   always_comb begin
      in_ready = 1'b0;
      p_valid  = 1'b0;
      busy     = 1'b1;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
         end
         DONE:    p_valid = 1'b1;
         default: ;
      endcase
   end

   // Datapath registers: operand capture, shift-and-add iteration, sign fix.
   always_ff @(posedge clk) begin
      if (rst) begin
         magA <= '0;
         magB <= '0;
         sign <= 1'b0;
         acc  <= '0;
         cnt  <= '0;
         pReg <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  magA <= N'(twosMag(aWide));
                  magB <= N'(twosMag(bWide));
                  sign <= a[N-1] ^ b[N-1];
                  acc  <= '0;
                  cnt  <= '0;
               end
            end
            RUN: begin
               if (magB[0]) begin
                  acc <= addSum;
               end
               magB <= magB >> 1;
               cnt  <= cnt + CW'(1);
            end
            FIX: begin
               pReg <= addSum;
            end
            default: ;
         endcase
      end
   end

   assign p = pReg;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: self-checking bench for mult_seq_ctrl at N=5.
// Expected products are pushed to a queue when operands are offered and
// popped when p_valid is seen; latency, handshakes and reset are checked inline.
// Honours MULT_EARLY_TERM_EN for the expected latency.
module tb_mult_seq_ctrl;

   localparam int N       = 5;
   localparam int PW      = 2 * N;
   localparam int MAX_LAT = 4 * N;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  a;
   logic [N-1:0]  b;
   logic          p_valid;
   logic          p_ready;
   logic [PW-1:0] p;
   logic          busy;

   logic [PW-1:0] expQ[$];
   int            assertCount = 0;
   int            failCount   = 0;

   mult_seq_ctrl #(.N(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .p_valid  (p_valid),
      .p_ready  (p_ready),
      .p        (p),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Reference product: integer multiply of the signed operands, kept to 2N bits.
   function automatic logic [PW-1:0] modelProduct(input logic [N-1:0] av, input logic [N-1:0] bv);
      int sa;
      int sb;
      logic [31:0] bits;
      sa   = int'($signed(av));
      sb   = int'($signed(bv));
      bits = sa * sb;
      return bits[PW-1:0];
   endfunction

   // Expected cycles from the acceptance edge to the first p_valid cycle.
   function automatic int expLatency(input logic [N-1:0] bv);
`ifdef MULT_EARLY_TERM_EN
      int sb;
      logic [31:0] mag;
      int top;
      sb  = int'($signed(bv));
      mag = (sb < 0) ? -sb : sb;
      top = 0;
      for (int i = 0; i <= N; i++) if (mag[i]) top = i;
      return ((top + 1 > 1) ? top + 1 : 1) + 1;
`else
      return N + 1;
`endif
   endfunction

   // One transaction; starts and ends just after a falling edge.
   // hold > 0 keeps p_ready low for that many cycles after p_valid rises.
   task automatic runTxn(input logic [N-1:0] av, input logic [N-1:0] bv, input int hold);
      int lat;
      logic [PW-1:0] expP;
      a        = av;
      b        = bv;
      in_valid = 1'b1;
      p_ready  = (hold == 0);
      assertCount++;
      if (in_ready !== 1'b1) begin
         failCount++;
         $display("FAIL accept_ready a=%0d b=%0d: in_ready=%b expected 1", $signed(av), $signed(bv), in_ready);
      end
      expQ.push_back(modelProduct(av, bv));
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      assertCount++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         failCount++;
         $display("FAIL busy_after_accept: busy=%b in_ready=%b expected 1/0", busy, in_ready);
      end
      lat = 0;
      while (p_valid !== 1'b1 && lat < MAX_LAT) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      assertCount++;
      if (p_valid !== 1'b1) begin
         failCount++;
         $display("FAIL timeout a=%0d b=%0d: no p_valid within %0d cycles", $signed(av), $signed(bv), MAX_LAT);
         void'(expQ.pop_front());
         return;
      end
      assertCount++;
      if (lat != expLatency(bv)) begin
         failCount++;
         $display("FAIL latency a=%0d b=%0d: got %0d expected %0d", $signed(av), $signed(bv), lat, expLatency(bv));
      end
      assertCount++;
      if (expQ.size() == 0) begin
         failCount++;
         $display("FAIL scoreboard_empty: product 0x%0h with nothing expected", p);
         return;
      end
      expP = expQ.pop_front();
      if (p !== expP) begin
         failCount++;
         $display("FAIL product a=%0d b=%0d: p=0x%03h expected 0x%03h", $signed(av), $signed(bv), p, expP);
      end
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         a        = ~av;
         b        = bv + N'(1);
         @(posedge clk);
         @(negedge clk);
         assertCount++;
         if (p_valid !== 1'b1 || p !== expP || in_ready !== 1'b0) begin
            failCount++;
            $display("FAIL hold_%0d: p_valid=%b p=0x%03h in_ready=%b expected 1/0x%03h/0", i, p_valid, p, in_ready, expP);
         end
      end
      in_valid = 1'b0;
      p_ready  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      assertCount++;
      if (p_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         failCount++;
         $display("FAIL after_handshake: p_valid=%b in_ready=%b busy=%b expected 0/1/0", p_valid, in_ready, busy);
      end
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      p_ready  = 1'b1;
      a        = '0;
      b        = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      assertCount++;
      if (in_ready !== 1'b1 || p_valid !== 1'b0 || busy !== 1'b0 || p !== '0) begin
         failCount++;
         $display("FAIL reset_state: in_ready=%b p_valid=%b busy=%b p=0x%0h expected 1/0/0/0", in_ready, p_valid, busy, p);
      end
   endtask

   task automatic test_basic();
      runTxn(N'(3), N'(5), 0);            // 0x00F
      runTxn(N'(-3), N'(5), 0);           // 0x3F1
      runTxn(N'(-16), N'(-16), 0);        // 0x100
      runTxn(N'(-3), N'(0), 0);           // 0x000, sign not applied to zero
   endtask

   task automatic test_boundaries();
      runTxn(N'(-16), N'(15), 0);
      runTxn(N'(15), N'(-16), 0);
      runTxn(N'(15), N'(15), 0);
      runTxn(N'(-1), N'(-1), 0);
      runTxn(N'(0), N'(-16), 0);
   endtask

   task automatic test_hold();
      runTxn(N'(7), N'(-9), 4);           // 0x3C1 held for four cycles
   endtask

   task automatic test_reset_mid();
      int seen;
      a        = N'(11);
      b        = N'(13);
      in_valid = 1'b1;
      @(posedge clk);                     // acceptance edge
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);                     // RUN edge 1
      @(posedge clk);                     // RUN edge 2
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);                     // would be RUN edge 3
      @(negedge clk);
      rst = 1'b0;
      assertCount++;
      if (in_ready !== 1'b1 || p_valid !== 1'b0 || busy !== 1'b0 || p !== '0) begin
         failCount++;
         $display("FAIL mid_reset_state: in_ready=%b p_valid=%b busy=%b p=0x%0h expected 1/0/0/0", in_ready, p_valid, busy, p);
      end
      seen = 0;
      repeat (N + 3) begin
         @(posedge clk);
         @(negedge clk);
         if (p_valid === 1'b1) seen++;
      end
      assertCount++;
      if (seen != 0) begin
         failCount++;
         $display("FAIL mid_reset_no_product: p_valid seen %0d cycles expected 0", seen);
      end
      runTxn(N'(2), N'(2), 0);            // 0x004 at normal latency
   endtask

   task automatic test_early_term();
      runTxn(N'(9), N'(1), 0);            // 0x009
      runTxn(N'(9), N'(4), 0);            // 0x024
      runTxn(N'(9), N'(0), 0);
      runTxn(N'(9), N'(-1), 0);
      runTxn(N'(-5), N'(8), 0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         runTxn(N'($urandom_range(0, 31)), N'($urandom_range(0, 31)), (i == 3) ? 2 : 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_basic();
      test_boundaries();
      test_hold();
      test_reset_mid();
      test_early_term();
      test_back_to_back();
      assertCount++;
      if (expQ.size() != 0) begin
         failCount++;
         $display("FAIL scoreboard_leftover: %0d products never seen", expQ.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
